ram_bist_master: RTL and testbench
==================================

// Module: ram_bist_master
// PURPOSE
//  Initiator for the single-port s_ram: sequences a write pass then a read-back pass over an address window.
//  Compares read data against a generated pattern; reports pass/fail, error count and first failing address.
//  Sits between test/control logic and the s_ram port; drives addr/data_in/en, consumes data_out.
// PARAMETERS
//  ADDR_W  4  RAM address width; depth = 2**ADDR_W
//  DATA_W  8  RAM data width
//  RD_LAT  1  RAM read latency in cycles (data_out valid RD_LAT cycles after read addr presented), 1..4
//  CNT_W   8  error counter width
// PORTS
//  clk             in   1         clock, rising edge
//  rst             in   1         synchronous reset, active-high
//  start           in   1         begin run; sampled only in IDLE
//  base_addr       in   ADDR_W    first address of window
//  length          in   ADDR_W+1  number of words, 0..2**ADDR_W
//  pat_sel         in   2         00 addr, 01 ~addr, 10 checkerboard (even 0x55.., odd 0xAA..), 11 all-ones
//  ram_addr        out  ADDR_W    to s_ram addr
//  ram_en          out  1         to s_ram en: 1 = write data_in at addr, 0 = read
//  ram_wdata       out  DATA_W    to s_ram data_in
//  ram_rdata       in   DATA_W    from s_ram data_out
//  busy            out  1         high from cycle after start accepted until done cycle inclusive
//  done            out  1         one-cycle pulse at end of run
//  pass            out  1         1 if err_count==0; valid with done, held until next accepted start
//  err_count       out  CNT_W     mismatches this run, saturates at 2**CNT_W-1
//  first_err_addr  out  ADDR_W    address of first mismatch; 0 if none
// BEHAVIOUR
//  Reset: state IDLE; ram_en=0, ram_addr=0, ram_wdata=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0.
//  FSM IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
//  IDLE: ram_en=0. On start: latch base/length/pat_sel, clear err_count/first_err_addr/pass.
//    length==0 -> go DONE directly (no RAM access, pass=1). Else -> WRITE.
//  WRITE: L cycles; cycle i drives ram_en=1, ram_addr=base+i, ram_wdata=pattern(base+i).
//  READ: L cycles; ram_en=0, ram_addr=base+i; expected addr pushed into RD_LAT-deep delay line.
//  DRAIN: RD_LAT cycles; ram_en=0; remaining compares complete.
//  Compare: RD_LAT cycles after each read addr, ram_rdata vs pattern(delayed addr).
//    Mismatch -> err_count+1 (saturating); first mismatch latches first_err_addr.
//  DONE: one cycle; done=1, busy=1, pass=(err_count==0); then IDLE, busy=0.
//  Latency: start sampled at edge N -> done high in cycle N+2L+RD_LAT+1 (L>0); N+1 for L==0.
//  Address arithmetic mod 2**ADDR_W: window past top wraps to 0; pattern uses the wrapped address.
//  length > 2**ADDR_W not representable; length==2**ADDR_W covers whole array once.
//  start while not IDLE: ignored, no effect on the run in progress.
//  start in the DONE cycle: ignored; start is accepted only in IDLE.
//  Inputs base_addr/length/pat_sel may change after acceptance without effect.
//  rst mid-run: next cycle IDLE, ram_en=0, all outputs at reset values; partially written RAM not restored.
//  ram_en never 1 outside WRITE.
// STRUCTURE
//  ram_bist_pkg: state_t enum {IDLE,WRITE,READ,DRAIN,DONE}; pat_t enum; function pattern(addr, pat).
//  Sub-module ram_bist_cmp: RD_LAT delay line + comparator + saturating err counter + first-err capture.
//  Top holds the FSM, the address/length counters and the RAM drive regs.
// TESTING (ADDR_W=4, DATA_W=8, RD_LAT=1, s_ram model)
//  base=0, len=16, pat=00 -> writes 0x00..0x0F; done at start+34; pass=1, err_count=0.
//  base=14, len=4, pat=10 -> addr seq 14,15,0,1; data 0x55,0xAA,0x55,0xAA; pass=1.
//  len=0 -> done at start+1, pass=1, ram_en stays 0, no addr change.
//  Model forces rdata bit0 flip at addr 5 and 9, base=0 len=16 pat=01 -> err_count=2, first_err_addr=5, pass=0.
//  rst asserted during READ -> next cycle busy=0, done=0, ram_en=0; new start runs cleanly to pass=1.
//  start pulsed during WRITE with different base -> ignored; done timing and addresses match original run.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types and the data-pattern generator for the RAM BIST master.
// Holds the FSM state encoding, the pattern selector encoding and the
// pattern() function used both when writing and when checking read-back data.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'b00,
    PAT_NADDR = 2'b01,
    PAT_CHECK = 2'b10,
    PAT_ONES  = 2'b11
  } pat_t;

  // Widest data word the generator supports; callers size-cast the result
  // down to their own DATA_W.
  localparam int PAT_W = 64;

  // Pattern word for a (wrapped) RAM address. The address is zero-extended
  // before use, so ~addr inverts the full data word.
  function automatic logic [PAT_W-1:0] pattern(input logic [31:0] addr, input pat_t pat);
    logic [PAT_W-1:0] w;
    case (pat)
      PAT_ADDR:  w = {32'd0, addr};
      PAT_NADDR: w = ~{32'd0, addr};
      PAT_CHECK: w = addr[0] ? {32{2'b10}} : {32{2'b01}};
      default:   w = '1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-back checker for the RAM BIST master.
// Delays each issued read address by RD_LAT cycles so it lines up with the
// RAM's data_out, compares against the expected pattern, counts mismatches
// (saturating) and captures the address of the first mismatch.
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   clr             clear counter, first-error address and delay line
//   rd_vld, rd_addr read issued this cycle and its address
//   pat             pattern selected for the current run
//   ram_rdata       RAM data_out
//   err_count       mismatch count, saturating
//   first_err_addr  address of first mismatch, 0 if none
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              rd_vld,
  input  logic [ADDR_W-1:0] rd_addr,
  input  pat_t              pat,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              dly_vld_q  [RD_LAT];
  logic              dly_vld_d  [RD_LAT];
  logic [ADDR_W-1:0] dly_addr_q [RD_LAT];
  logic [ADDR_W-1:0] dly_addr_d [RD_LAT];
  logic [CNT_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fea_q, fea_d;
  logic [DATA_W-1:0] exp_data;
  logic              mismatch;

  always_comb begin
    dly_vld_d[0]  = rd_vld;
    dly_addr_d[0] = rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      dly_vld_d[i]  = dly_vld_q[i-1];
      dly_addr_d[i] = dly_addr_q[i-1];
    end

    // The last delay stage lines up with the RAM's data_out.
    exp_data = DATA_W'(pattern(32'(dly_addr_q[RD_LAT-1]), pat));
    mismatch = dly_vld_q[RD_LAT-1] && (ram_rdata != exp_data);

    err_d = err_q;
    fea_d = fea_q;
    if (clr) begin
      err_d = '0;
      fea_d = '0;
      for (int i = 0; i < RD_LAT; i++) dly_vld_d[i] = 1'b0;
    end else if (mismatch) begin
      // A zero count means no mismatch has been seen yet this run.
      if (err_q == '0) fea_d = dly_addr_q[RD_LAT-1];
      if (err_q != CNT_MAX) err_d = err_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        dly_vld_q[i]  <= 1'b0;
        dly_addr_q[i] <= '0;
      end
      err_q <= '0;
      fea_q <= '0;
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        dly_vld_q[i]  <= dly_vld_d[i];
        dly_addr_q[i] <= dly_addr_d[i];
      end
      err_q <= err_d;
      fea_q <= fea_d;
    end
  end

  assign err_count      = err_q;
  assign first_err_addr = fea_q;

endmodule

// File: rtl/ram_bist_master.sv
// BIST initiator for a single-port synchronous RAM. On start it writes a
// generated pattern over an address window, reads the window back, and
// reports pass/fail, mismatch count and first failing address.
// Ports:
//   clk, rst                    clock / synchronous active-high reset
//   start                       begin a run (honoured only when idle)
//   base_addr, length, pat_sel  window and pattern, latched at start
//   ram_addr, ram_en, ram_wdata RAM drive (ram_en=1 write, 0 read)
//   ram_rdata                   RAM data_out
//   busy, done, pass            run status
//   err_count, first_err_addr   result of the read-back compare
module ram_bist_master
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [1:0]        pat_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int             IDX_W   = ADDR_W + 1;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  len_q, len_d;
  pat_t              pat_q, pat_d;
  logic              pass_q, pass_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              start_acc;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    len_d     = len_q;
    pat_d     = pat_q;
    pass_d    = pass_q;
    start_acc = 1'b0;
    idx_inc   = idx_q + IDX_ONE;

    // idx counts cycles within the current phase.
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          base_d    = base_addr;
          len_d     = length;
          pat_d     = pat_t'(pat_sel);
          pass_d    = 1'b0;
          idx_d     = '0;
          state_d   = (length == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (idx_inc == len_q) begin
          idx_d   = '0;
          state_d = ST_READ;
        end else begin
          idx_d = idx_inc;
        end
      end
      ST_READ: begin
        if (idx_inc == len_q) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_inc;
        end
      end
      ST_DRAIN: begin
        if (idx_inc == IDX_W'(RD_LAT)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_inc;
        end
      end
      ST_DONE: begin
        // Final compare landed on the edge into DONE, so err_count is settled.
        pass_d  = (err_count == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // RAM drive is registered from the next state so it is aligned with
    // state_q in the cycle it applies to. Address holds outside WRITE/READ.
    ram_en_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (state_d == ST_WRITE || state_d == ST_READ)
      ram_addr_d = base_d + idx_d[ADDR_W-1:0];
    if (state_d == ST_WRITE) begin
      ram_en_d    = 1'b1;
      ram_wdata_d = DATA_W'(pattern(32'(ram_addr_d), pat_d));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      len_q       <= '0;
      pat_q       <= PAT_ADDR;
      pass_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      len_q       <= len_d;
      pat_q       <= pat_d;
      pass_q      <= pass_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  ram_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT),
    .CNT_W (CNT_W)
  ) u_cmp (
    .clk           (clk),
    .rst           (rst),
    .clr           (start_acc),
    .rd_vld        (state_q == ST_READ),
    .rd_addr       (ram_addr_q),
    .pat           (pat_q),
    .ram_rdata     (ram_rdata),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

  assign ram_addr  = ram_addr_q;
  assign ram_en    = ram_en_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  // During DONE the result is shown directly; afterwards the stored copy.
  assign pass      = (state_q == ST_DONE) ? (err_count == '0) : pass_q;

endmodule

// File: tb/tb_ram_bist_master.sv
module tb_ram_bist_master;

  localparam int RD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] length;
  logic [1:0] pat_sel;
  logic [3:0] ram_addr;
  logic       ram_en;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] first_err_addr;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ram_bist_master #(.ADDR_W(4), .DATA_W(8), .RD_LAT(RD_LAT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .pat_sel(pat_sel), .ram_addr(ram_addr), .ram_en(ram_en), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  // s_ram model: write on en, registered read; flip[] forces bit0 inversion on read.
  logic [7:0]  mem [16];
  logic [15:0] flip;
  always @(posedge clk) begin
    if (ram_en) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr] ^ {7'd0, flip[ram_addr]};
  end

  typedef struct {
    logic [3:0]  base;
    logic [4:0]  len;
    logic [1:0]  pat;
    logic [15:0] flip;
    int          exp_err;
    int          exp_first;
    bit          exp_pass;
    int          exp_donek;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_pat(input int a, input int p);
    case (p)
      0:       return 8'(a);
      1:       return ~8'(a);
      2:       return (a % 2 == 0) ? 8'h55 : 8'hAA;
      default: return 8'hFF;
    endcase
  endfunction

  // Reference: each window address is written then read once; a mismatch
  // occurs exactly where the RAM corrupts the read.
  task automatic model(input int b, input int l, input logic [15:0] f,
                       output int err, output int first, output bit ps, output int dk);
    err = 0;
    first = 0;
    for (int i = 0; i < l; i++) begin
      int a;
      a = (b + i) % 16;
      if (f[a]) begin
        if (err == 0) first = a;
        err++;
      end
    end
    ps = (err == 0);
    dk = (l == 0) ? 0 : 2 * l + RD_LAT;
  endtask

  // One run. k counts edges after the start-accepting edge (k=0).
  task automatic run(input logic [3:0] b, input logic [4:0] l, input logic [1:0] p,
                     input logic [15:0] f, input int e_err, input int e_first,
                     input bit e_pass, input int e_donek, input bit glitch,
                     input bit dc_start, input string tag);
    logic [3:0] wa[$];
    logic [7:0] wd[$];
    logic [3:0] addr_before;
    int k, donek, busy_bad;
    bit got;
    logic [7:0] r_err;
    logic [3:0] r_first;
    logic r_pass;
    @(negedge clk);
    flip = f;
    addr_before = ram_addr;
    start = 1'b1; base_addr = b; length = l; pat_sel = p;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    base_addr = 4'($urandom); length = 5'($urandom_range(0, 16)); pat_sel = 2'($urandom);
    k = 0; got = 0; donek = -1; busy_bad = 0;
    r_err = '0; r_first = '0; r_pass = 1'b0;
    while (k < 200 && !got) begin
      if (ram_en) begin
        wa.push_back(ram_addr);
        wd.push_back(ram_wdata);
      end
      if (!busy) busy_bad++;
      if (glitch && k == 3) begin start = 1'b1; base_addr = b + 4'd5; length = 5'd2; end
      if (glitch && k == 4) start = 1'b0;
      if (done) begin
        got = 1; donek = k;
        r_err = err_count; r_first = first_err_addr; r_pass = pass;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_done_time"}, 32'(donek), 32'(e_donek));
    chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
    chk({tag, "_err_count"}, 32'(r_err), 32'(e_err));
    chk({tag, "_first_err"}, 32'(r_first), 32'(e_first));
    chk({tag, "_pass"}, 32'(r_pass), 32'(e_pass));
    chk({tag, "_n_writes"}, 32'(wa.size()), 32'(l));
    for (int i = 0; i < wa.size() && i < int'(l); i++) begin
      chk({tag, "_wr_addr"}, 32'(wa[i]), 32'((int'(b) + i) % 16));
      chk({tag, "_wr_data"}, 32'(wd[i]), 32'(tb_pat((int'(b) + i) % 16, int'(p))));
    end
    if (l == 0) chk({tag, "_len0_addr"}, 32'(ram_addr), 32'(addr_before));
    if (dc_start) begin
      start = 1'b1; base_addr = 4'd3; length = 5'd4; pat_sel = 2'd0;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_post_busy"}, 32'(busy), 32'd0);
    chk({tag, "_post_done"}, 32'(done), 32'd0);
    chk({tag, "_post_pass"}, 32'(pass), 32'(e_pass));
  endtask

  initial begin
    int e_err, e_first, e_dk;
    bit e_ps;
    logic [3:0] rb;
    logic [4:0] rl;
    logic [1:0] rp;
    logic [15:0] rf;

    tbl[0] = '{base: 4'd0,  len: 5'd16, pat: 2'd0, flip: 16'h0000, exp_err: 0, exp_first: 0,  exp_pass: 1, exp_donek: 33};
    tbl[1] = '{base: 4'd14, len: 5'd4,  pat: 2'd2, flip: 16'h0000, exp_err: 0, exp_first: 0,  exp_pass: 1, exp_donek: 9};
    tbl[2] = '{base: 4'd7,  len: 5'd0,  pat: 2'd1, flip: 16'hFFFF, exp_err: 0, exp_first: 0,  exp_pass: 1, exp_donek: 0};
    tbl[3] = '{base: 4'd0,  len: 5'd16, pat: 2'd1, flip: 16'h0220, exp_err: 2, exp_first: 5,  exp_pass: 0, exp_donek: 33};
    tbl[4] = '{base: 4'd10, len: 5'd8,  pat: 2'd3, flip: 16'h1002, exp_err: 2, exp_first: 12, exp_pass: 0, exp_donek: 17};

    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; pat_sel = '0; flip = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_en", 32'(ram_en), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_first", 32'(first_err_addr), 32'd0);
    rst = 1'b0;

    for (int t = 0; t < 5; t++)
      run(tbl[t].base, tbl[t].len, tbl[t].pat, tbl[t].flip, tbl[t].exp_err,
          tbl[t].exp_first, tbl[t].exp_pass, tbl[t].exp_donek, 1'b0, 1'b0,
          $sformatf("tbl%0d", t));

    // Start pulsed mid-WRITE with another window, and start held in the DONE cycle.
    run(4'd0, 5'd16, 2'd0, 16'h0000, 0, 0, 1'b1, 33, 1'b1, 1'b1, "glitch");

    // Reset during READ.
    @(negedge clk);
    flip = '0;
    start = 1'b1; base_addr = 4'd0; length = 5'd16; pat_sel = 2'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    chk("midrst_pre_en", 32'(ram_en), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_en", 32'(ram_en), 32'd0);
    chk("midrst_addr", 32'(ram_addr), 32'd0);
    chk("midrst_err", 32'(err_count), 32'd0);
    chk("midrst_pass", 32'(pass), 32'd0);
    rst = 1'b0;
    model(3, 11, 16'h0000, e_err, e_first, e_ps, e_dk);
    run(4'd3, 5'd11, 2'd2, 16'h0000, e_err, e_first, e_ps, e_dk, 1'b0, 1'b0, "after_rst");

    // Randomized runs against the reference model.
    for (int t = 0; t < 20; t++) begin
      rb = 4'($urandom);
      rl = 5'($urandom_range(0, 16));
      rp = 2'($urandom);
      rf = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      model(int'(rb), int'(rl), rf, e_err, e_first, e_ps, e_dk);
      run(rb, rl, rp, rf, e_err, e_first, e_ps, e_dk, 1'b0, 1'b0, $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
